// File: rtl/rob_pkg.sv
// Shared constants, payload types and retire helper for the reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_DEPTH  = 32;
  localparam int unsigned ROB_PREG_W = 6;
  localparam int unsigned LREG_W     = 5;
  localparam int unsigned PC_W       = 48;

  typedef logic [LREG_W-1:0] lreg_t;
  typedef logic [PC_W-1:0]   pc_t;

  // Number of entries retired this cycle given the two slot selections.
  function automatic logic [1:0] retire_count(input logic slot0, input logic slot1);
    return slot0 ? (slot1 ? 2'd2 : 2'd1) : 2'd0;
  endfunction

endpackage

// File: rtl/rob_if.sv
// Dispatch / writeback / commit / freelist-release bundle of the reorder buffer.
interface rob_if
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned PREG_W = ROB_PREG_W
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  // dispatch
  logic              enq_valid;
  logic              enq_ready;
  logic              enq_need_to_wb;
  lreg_t             enq_lrd;
  logic [PREG_W-1:0] enq_prd;
  logic [PREG_W-1:0] enq_old_prd;
  pc_t               enq_pc;
  logic [IDX_W-1:0]  enq_robidx;
  // writeback completions
  logic              wb0_valid;
  logic [IDX_W-1:0]  wb0_robidx;
  logic              wb1_valid;
  logic [IDX_W-1:0]  wb1_robidx;
  // retirement
  logic              commit0_valid;
  logic              commit0_need_to_wb;
  lreg_t             commit0_lrd;
  logic [PREG_W-1:0] commit0_prd;
  logic [PREG_W-1:0] commit0_old_prd;
  pc_t               commit0_pc;
  logic              commit1_valid;
  logic              commit1_need_to_wb;
  lreg_t             commit1_lrd;
  logic [PREG_W-1:0] commit1_prd;
  logic [PREG_W-1:0] commit1_old_prd;
  pc_t               commit1_pc;
  // freelist release
  logic              write0_valid;
  logic [PREG_W-1:0] write0_data;
  logic              write1_valid;
  logic [PREG_W-1:0] write1_data;
  // occupancy
  logic [IDX_W:0]    count;

  modport master (
    output enq_valid, enq_need_to_wb, enq_lrd, enq_prd, enq_old_prd, enq_pc,
    output wb0_valid, wb0_robidx, wb1_valid, wb1_robidx,
    input  enq_ready, enq_robidx, count,
    input  commit0_valid, commit0_need_to_wb, commit0_lrd, commit0_prd, commit0_old_prd, commit0_pc,
    input  commit1_valid, commit1_need_to_wb, commit1_lrd, commit1_prd, commit1_old_prd, commit1_pc,
    input  write0_valid, write0_data, write1_valid, write1_data
  );

  modport slave (
    input  enq_valid, enq_need_to_wb, enq_lrd, enq_prd, enq_old_prd, enq_pc,
    input  wb0_valid, wb0_robidx, wb1_valid, wb1_robidx,
    output enq_ready, enq_robidx, count,
    output commit0_valid, commit0_need_to_wb, commit0_lrd, commit0_prd, commit0_old_prd, commit0_pc,
    output commit1_valid, commit1_need_to_wb, commit1_lrd, commit1_prd, commit1_old_prd, commit1_pc,
    output write0_valid, write0_data, write1_valid, write1_data
  );

endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocation, out-of-order completion, up to two
// in-order retirements per cycle with registered commit/freelist outputs.
module rob
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned PREG_W = ROB_PREG_W
) (
  input logic  clock,
  input logic  reset_n,
  input logic  flush,
  rob_if.slave io
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef logic [IDX_W:0]    ptr_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    logic  need_to_wb;
    lreg_t lrd;
    preg_t prd;
    preg_t old_prd;
    pc_t   pc;
  } commit_t;

  // entry state
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] complete_q, complete_d;
  // entry payload (only read while the entry is valid, so left unreset)
  logic             need_q    [DEPTH];
  lreg_t            lrd_q     [DEPTH];
  preg_t            prd_q     [DEPTH];
  preg_t            old_prd_q [DEPTH];
  pc_t              pc_q      [DEPTH];

  ptr_t    head_q, head_d;
  ptr_t    tail_q, tail_d;
  ptr_t    count_q, count_d;
  commit_t c0_q, c0_d, c1_q, c1_d;

  idx_t       head_idx, head1_idx, tail_idx;
  logic       full, enq_ready, enq_fire;
  logic       sel0, sel1;
  logic [1:0] ncommit;

  assign head_idx  = head_q[IDX_W-1:0];
  assign head1_idx = head_idx + idx_t'(1);
  assign tail_idx  = tail_q[IDX_W-1:0];

  assign full      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign enq_ready = !full && !flush;
  assign enq_fire  = io.enq_valid && enq_ready;

  // selection looks only at registered state, so a same-cycle writeback
  // to the head cannot retire it in that cycle
  assign sel0    = valid_q[head_idx] && complete_q[head_idx];
  assign sel1    = sel0 && valid_q[head1_idx] && complete_q[head1_idx];
  assign ncommit = retire_count(sel0, sel1);

  // next-state: writeback marks, allocation, retirement, flush override
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    c0_d       = '0;
    c1_d       = '0;
    if (flush) begin
      valid_d    = '0;
      complete_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (io.wb0_valid && valid_q[io.wb0_robidx]) complete_d[io.wb0_robidx] = 1'b1;
      if (io.wb1_valid && valid_q[io.wb1_robidx]) complete_d[io.wb1_robidx] = 1'b1;
      if (enq_fire) begin
        valid_d[tail_idx]    = 1'b1;
        complete_d[tail_idx] = 1'b0;
        tail_d               = tail_q + ptr_t'(1);
      end
      // retirement clears are applied last so they win over a redundant writeback
      if (sel0) begin
        valid_d[head_idx]    = 1'b0;
        complete_d[head_idx] = 1'b0;
        c0_d.valid           = 1'b1;
        c0_d.need_to_wb      = need_q[head_idx];
        c0_d.lrd             = lrd_q[head_idx];
        c0_d.prd             = prd_q[head_idx];
        c0_d.old_prd         = old_prd_q[head_idx];
        c0_d.pc              = pc_q[head_idx];
      end
      if (sel1) begin
        valid_d[head1_idx]    = 1'b0;
        complete_d[head1_idx] = 1'b0;
        c1_d.valid            = 1'b1;
        c1_d.need_to_wb       = need_q[head1_idx];
        c1_d.lrd              = lrd_q[head1_idx];
        c1_d.prd              = prd_q[head1_idx];
        c1_d.old_prd          = old_prd_q[head1_idx];
        c1_d.pc               = pc_q[head1_idx];
      end
      head_d  = head_q + ptr_t'(ncommit);
      count_d = count_q + ptr_t'(enq_fire) - ptr_t'(ncommit);
    end
  end

  // state and commit registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
    end
  end

  // payload capture at the tail on an accepted enqueue
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      need_q[tail_idx]    <= io.enq_need_to_wb;
      lrd_q[tail_idx]     <= io.enq_lrd;
      prd_q[tail_idx]     <= io.enq_prd;
      old_prd_q[tail_idx] <= io.enq_old_prd;
      pc_q[tail_idx]      <= io.enq_pc;
    end
  end

  assign io.enq_ready          = enq_ready;
  assign io.enq_robidx         = tail_idx;
  assign io.count              = count_q;

  assign io.commit0_valid      = c0_q.valid;
  assign io.commit0_need_to_wb = c0_q.need_to_wb;
  assign io.commit0_lrd        = c0_q.lrd;
  assign io.commit0_prd        = c0_q.prd;
  assign io.commit0_old_prd    = c0_q.old_prd;
  assign io.commit0_pc         = c0_q.pc;

  assign io.commit1_valid      = c1_q.valid;
  assign io.commit1_need_to_wb = c1_q.need_to_wb;
  assign io.commit1_lrd        = c1_q.lrd;
  assign io.commit1_prd        = c1_q.prd;
  assign io.commit1_old_prd    = c1_q.old_prd;
  assign io.commit1_pc         = c1_q.pc;

  assign io.write0_valid       = c0_q.valid && c0_q.need_to_wb;
  assign io.write0_data        = c0_q.old_prd;
  assign io.write1_valid       = c1_q.valid && c1_q.need_to_wb;
  assign io.write1_data        = c1_q.old_prd;

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios followed by random traffic, checked against
// a program-order queue model of the buffer.
module tb_rob;
  import rob_pkg::*;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned PREG_W = 6;
  localparam int unsigned IDX_W  = 5;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [PREG_W-1:0] preg_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  rob_if #(.DEPTH(DEPTH), .PREG_W(PREG_W)) bus ();

  rob #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .io      (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned idx;
    bit          done;
    logic        nwb;
    lreg_t       lrd;
    preg_t       prd;
    preg_t       old;
    pc_t         pc;
  } ent_t;

  ent_t        q[$];
  int unsigned tail_m = 0;
  ent_t        exp_c[2];
  bit          exp_v[2] = '{1'b0, 1'b0};
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: queue in program order; head retires when done, next one too if done.
  task automatic model_edge();
    int unsigned pre;
    int unsigned n;
    pre = q.size();
    n   = 0;
    exp_v[0] = 1'b0;
    exp_v[1] = 1'b0;
    if (!reset_n || flush) begin
      q.delete();
      tail_m = 0;
      return;
    end
    if (pre > 0 && q[0].done) n = 1;
    if (n == 1 && pre > 1 && q[1].done) n = 2;
    for (int unsigned i = 0; i < n; i++) begin
      exp_v[i] = 1'b1;
      exp_c[i] = q[i];
    end
    for (int unsigned i = 0; i < pre; i++) begin
      if ((bus.wb0_valid && q[i].idx == int'(bus.wb0_robidx)) ||
          (bus.wb1_valid && q[i].idx == int'(bus.wb1_robidx)))
        q[i].done = 1'b1;
    end
    for (int unsigned i = 0; i < n; i++) q.delete(0);
    if (bus.enq_valid && pre < DEPTH) begin
      ent_t e;
      e.idx  = tail_m;
      e.done = 1'b0;
      e.nwb  = bus.enq_need_to_wb;
      e.lrd  = bus.enq_lrd;
      e.prd  = bus.enq_prd;
      e.old  = bus.enq_old_prd;
      e.pc   = bus.enq_pc;
      q.push_back(e);
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  task automatic check_comb();
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("enq_ready", 64'(bus.enq_ready), 64'(q.size() < DEPTH && !flush));
    chk("enq_robidx", 64'(bus.enq_robidx), 64'(tail_m));
  endtask

  task automatic check_slot(input int unsigned s, input logic v, input logic nwb, input lreg_t lrd,
                            input preg_t prd, input preg_t old, input pc_t pc,
                            input logic wv, input preg_t wd);
    ent_t e;
    bit   ev;
    e  = exp_c[s];
    ev = exp_v[s];
    chk($sformatf("c%0d_valid", s),   64'(v),   64'(ev));
    chk($sformatf("c%0d_nwb", s),     64'(nwb), ev ? 64'(e.nwb) : 64'd0);
    chk($sformatf("c%0d_lrd", s),     64'(lrd), ev ? 64'(e.lrd) : 64'd0);
    chk($sformatf("c%0d_prd", s),     64'(prd), ev ? 64'(e.prd) : 64'd0);
    chk($sformatf("c%0d_old_prd", s), 64'(old), ev ? 64'(e.old) : 64'd0);
    chk($sformatf("c%0d_pc", s),      64'(pc),  ev ? 64'(e.pc)  : 64'd0);
    chk($sformatf("w%0d_valid", s),   64'(wv),  64'(ev && e.nwb));
    chk($sformatf("w%0d_data", s),    64'(wd),  ev ? 64'(e.old) : 64'd0);
  endtask

  task automatic check_regs();
    check_slot(0, bus.commit0_valid, bus.commit0_need_to_wb, bus.commit0_lrd, bus.commit0_prd,
               bus.commit0_old_prd, bus.commit0_pc, bus.write0_valid, bus.write0_data);
    check_slot(1, bus.commit1_valid, bus.commit1_need_to_wb, bus.commit1_lrd, bus.commit1_prd,
               bus.commit1_old_prd, bus.commit1_pc, bus.write1_valid, bus.write1_data);
  endtask

  // One clock: inputs already driven at the negedge.
  task automatic tick();
    #1;
    check_comb();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_regs();
    bus.enq_valid = 1'b0;
    bus.wb0_valid = 1'b0;
    bus.wb1_valid = 1'b0;
    flush         = 1'b0;
    reset_n       = 1'b1;
  endtask

  task automatic enq(input logic nwb, input lreg_t lrd, input preg_t prd, input preg_t old, input pc_t pc);
    bus.enq_valid      = 1'b1;
    bus.enq_need_to_wb = nwb;
    bus.enq_lrd        = lrd;
    bus.enq_prd        = prd;
    bus.enq_old_prd    = old;
    bus.enq_pc         = pc;
  endtask

  task automatic wb0(input idx_t i);
    bus.wb0_valid  = 1'b1;
    bus.wb0_robidx = i;
  endtask

  task automatic wb1(input idx_t i);
    bus.wb1_valid  = 1'b1;
    bus.wb1_robidx = i;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
  endtask

  initial begin
    bus.enq_valid      = 1'b0;
    bus.enq_need_to_wb = 1'b0;
    bus.enq_lrd        = '0;
    bus.enq_prd        = '0;
    bus.enq_old_prd    = '0;
    bus.enq_pc         = '0;
    bus.wb0_valid      = 1'b0;
    bus.wb0_robidx     = '0;
    bus.wb1_valid      = 1'b0;
    bus.wb1_robidx     = '0;

    // power-on reset: DUT state undefined before the first edge
    repeat (2) @(posedge clock);
    model_edge();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    chk("rst_enq_robidx", 64'(bus.enq_robidx), 64'd0);
    chk("rst_c0_valid", 64'(bus.commit0_valid), 64'd0);
    chk("rst_c1_valid", 64'(bus.commit1_valid), 64'd0);
    tick();

    // single entry, minimum latency
    do_reset();
    enq(1'b1, 5'd5, 6'd40, 6'd5, 48'h1000);
    tick();
    wb0(5'd0);
    tick();
    tick();
    chk("lat_c0_valid", 64'(bus.commit0_valid), 64'd1);
    chk("lat_c0_old_prd", 64'(bus.commit0_old_prd), 64'd5);
    chk("lat_c0_prd", 64'(bus.commit0_prd), 64'd40);
    chk("lat_w0_valid", 64'(bus.write0_valid), 64'd1);
    chk("lat_count", 64'(bus.count), 64'd0);
    tick();

    // out-of-order completion holds retirement at the head
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      enq(1'b1, lreg_t'(i + 1), preg_t'(10 + i), preg_t'(i + 1), pc_t'(48'h2000 + 4 * i));
      tick();
    end
    wb0(5'd1);
    wb1(5'd2);
    tick();
    tick();
    chk("ooo_c0_hold", 64'(bus.commit0_valid), 64'd0);
    wb0(5'd0);
    tick();
    tick();
    chk("ooo_c0_prd", 64'(bus.commit0_prd), 64'd10);
    chk("ooo_c1_valid", 64'(bus.commit1_valid), 64'd1);
    chk("ooo_c1_prd", 64'(bus.commit1_prd), 64'd11);
    tick();
    chk("ooo_c0_last", 64'(bus.commit0_prd), 64'd12);
    chk("ooo_c1_last", 64'(bus.commit1_valid), 64'd0);

    // fill, overflow attempt, drain, wrap
    do_reset();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      enq(1'b1, lreg_t'(i), preg_t'(i), preg_t'(63 - i), pc_t'(48'h3000 + 4 * i));
      tick();
    end
    #1;
    chk("full_enq_ready", 64'(bus.enq_ready), 64'd0);
    chk("full_count", 64'(bus.count), 64'd32);
    enq(1'b1, 5'd31, 6'd33, 6'd34, 48'hdead);
    tick();
    for (int unsigned i = 0; i < DEPTH / 2; i++) begin
      wb0(idx_t'(2 * i));
      wb1(idx_t'(2 * i + 1));
      tick();
    end
    repeat (20) tick();
    chk("wrap_count", 64'(bus.count), 64'd0);
    chk("wrap_enq_robidx", 64'(bus.enq_robidx), 64'd0);
    enq(1'b0, 5'd7, 6'd17, 6'd27, 48'h4000);
    tick();

    // non-writing instruction retires without freelist release
    do_reset();
    enq(1'b0, 5'd9, 6'd21, 6'd9, 48'h5000);
    tick();
    wb1(5'd0);
    tick();
    tick();
    chk("nwb_c0_valid", 64'(bus.commit0_valid), 64'd1);
    chk("nwb_w0_valid", 64'(bus.write0_valid), 64'd0);
    tick();

    // flush on the cycle the head pair would have been selected
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      enq(1'b1, lreg_t'(i), preg_t'(20 + i), preg_t'(i), pc_t'(48'h6000 + 4 * i));
      tick();
    end
    wb0(5'd0);
    wb1(5'd1);
    tick();
    flush = 1'b1;
    tick();
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_c0_valid", 64'(bus.commit0_valid), 64'd0);
    chk("flush_c1_valid", 64'(bus.commit1_valid), 64'd0);
    chk("flush_enq_robidx", 64'(bus.enq_robidx), 64'd0);
    enq(1'b1, 5'd3, 6'd30, 6'd3, 48'h7000);
    tick();

    // random traffic; alternating phases favour filling or draining
    for (int unsigned c = 0; c < 4000; c++) begin
      int unsigned wbp;
      wbp = ((c / 400) % 2 == 1) ? 15 : 70;
      if ($urandom_range(0, 99) < 60)
        enq(1'($urandom), lreg_t'($urandom), preg_t'($urandom), preg_t'($urandom),
            pc_t'({$urandom, $urandom}));
      if (q.size() > 0 && $urandom_range(0, 99) < wbp)
        wb0(idx_t'(q[$urandom_range(0, q.size() - 1)].idx));
      else if ($urandom_range(0, 99) < 10) begin
        idx_t r;
        r = idx_t'($urandom);
        if (int'(r) != tail_m) wb0(r);
      end
      if (q.size() > 0 && $urandom_range(0, 99) < wbp)
        wb1(idx_t'(q[$urandom_range(0, q.size() - 1)].idx));
      if ($urandom_range(0, 299) == 0) flush = 1'b1;
      if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
